// File: rtl/result_bus_arbiter_pkg.sv
// Shared flat-array helper macros and configuration checks for the result bus arbiter.
`ifndef RESULT_BUS_ARBITER_MACROS
`define RESULT_BUS_ARBITER_MACROS
`define FLAT_ARRAY(width, count) [(width)*(count)-1:0]
`define ARRAY(width, count) [(count)-1:0][(width)-1:0]
`define NORMAL_EQUALS_FLAT(normal, flat) assign normal = flat;
`endif

package result_bus_arbiter_pkg;

  localparam int unsigned MAX_BUS_COUNT = 4;

  // True when an index of the given width can address every station.
  function automatic bit index_size_ok(input int unsigned count, input int unsigned bits);
    return (count <= 1) || (bits >= $clog2(count));
  endfunction

endpackage

// File: rtl/result_bus_arbiter_picker.sv
// Circular first-ready picker: scans from a start index, skipping stations already taken.
module circular_priority_picker
  import result_bus_arbiter_pkg::*;
#(
  parameter int COUNT      = 4,
  parameter int INDEX_SIZE = 2
) (
  input  logic [COUNT-1:0]      i_request,
  input  logic [INDEX_SIZE-1:0] i_start,
  input  logic [COUNT-1:0]      i_taken,
  output logic                  o_found,
  output logic [INDEX_SIZE-1:0] o_index
);

  logic [INDEX_SIZE-1:0] w_scan;

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_scan  = i_start;
    for (int off = 0; off < COUNT; off++) begin
      if (!o_found && i_request[w_scan] && !i_taken[w_scan]) begin
        o_found = 1'b1;
        o_index = w_scan;
      end
      w_scan = (w_scan == INDEX_SIZE'(COUNT - 1)) ? '0 : w_scan + 1'b1;
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin driver of the common result bus: grants up to BUS_COUNT ready stations per
// cycle, releases them combinationally and presents their results one cycle later.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 1
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic `FLAT_ARRAY(1, STATION_COUNT)                station_ready,
  input  logic `FLAT_ARRAY(SIZE, STATION_COUNT)             station_result,
  output logic `FLAT_ARRAY(1, STATION_COUNT)                station_release,
  output logic `FLAT_ARRAY(1, BUS_COUNT)                    bus_asserted,
  output logic `FLAT_ARRAY(STATION_INDEX_SIZE, BUS_COUNT)   bus_source,
  output logic `FLAT_ARRAY(SIZE, BUS_COUNT)                 bus_value
);

  // A misconfigured instance never grants, so the fault is visible rather than silent.
  localparam bit CONFIG_OK = index_size_ok(STATION_COUNT, STATION_INDEX_SIZE)
                             && (BUS_COUNT >= 1) && (BUS_COUNT <= MAX_BUS_COUNT)
                             && (STATION_COUNT >= BUS_COUNT) && (STATION_COUNT >= 2);

  logic `ARRAY(SIZE, STATION_COUNT) w_results;
  `NORMAL_EQUALS_FLAT(w_results, station_result)

  logic [STATION_INDEX_SIZE-1:0] r_rr_pointer;
  logic [BUS_COUNT-1:0]          w_found;
  logic [STATION_INDEX_SIZE-1:0] w_pick [BUS_COUNT];
  logic                          w_enable;
  logic [STATION_INDEX_SIZE-1:0] w_last_pick;
  logic                          w_any_grant;

  assign w_enable = CONFIG_OK && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < BUS_COUNT; gi++) begin : g_bus
      logic [STATION_COUNT-1:0]      w_mask_in;
      logic [STATION_COUNT-1:0]      w_mask_out;
      logic                          w_hit;
      logic [STATION_INDEX_SIZE-1:0] w_index;
      logic                          r_asserted;
      logic [STATION_INDEX_SIZE-1:0] r_source;
      logic [SIZE-1:0]               r_value;

      // Each stage starts at the pointer but skips every earlier stage's pick.
      if (gi == 0) begin : g_first
        assign w_mask_in = '0;
      end else begin : g_next
        assign w_mask_in = g_bus[gi-1].w_mask_out;
      end

      circular_priority_picker #(
        .COUNT      (STATION_COUNT),
        .INDEX_SIZE (STATION_INDEX_SIZE)
      ) u_picker (
        .i_request (station_ready),
        .i_start   (r_rr_pointer),
        .i_taken   (w_mask_in),
        .o_found   (w_hit),
        .o_index   (w_index)
      );

      assign w_mask_out  = w_mask_in | (w_hit ? (STATION_COUNT'(1) << w_index) : '0);
      assign w_found[gi] = w_hit && w_enable;
      assign w_pick[gi]  = w_index;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_asserted <= 1'b0;
          r_source   <= '0;
          r_value    <= '0;
        end else begin
          r_asserted <= w_found[gi];
          if (w_found[gi]) begin
            r_source <= w_index;
            r_value  <= w_results[w_index];
          end
        end
      end

      assign bus_asserted[gi]                                          = r_asserted;
      assign bus_source[gi*STATION_INDEX_SIZE +: STATION_INDEX_SIZE]   = r_source;
      assign bus_value[gi*SIZE +: SIZE]                                = r_value;
    end
  endgenerate

  assign station_release = w_enable ? g_bus[BUS_COUNT-1].w_mask_out : '0;

  // Buses fill in order, so the last found pick is the highest-numbered granted bus.
  always_comb begin
    w_any_grant = 1'b0;
    w_last_pick = r_rr_pointer;
    for (int k = 0; k < BUS_COUNT; k++) begin
      if (w_found[k]) begin
        w_any_grant = 1'b1;
        w_last_pick = w_pick[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_pointer <= '0;
    end else if (w_any_grant) begin
      r_rr_pointer <= (w_last_pick == STATION_INDEX_SIZE'(STATION_COUNT - 1)) ?
                      '0 : w_last_pick + 1'b1;
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench: a single-bus and a dual-bus arbiter, four stations each.
module tb_result_bus_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   rdy1, rdy2, rel1, rel2;
  logic [127:0] res1, res2;
  logic [0:0]   asrt1;
  logic [1:0]   src1;
  logic [31:0]  val1;
  logic [1:0]   asrt2;
  logic [3:0]   src2;
  logic [63:0]  val2;

  always #5 clock = ~clock;

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(1)) u_one (
    .clock(clock), .reset(reset), .station_ready(rdy1), .station_result(res1),
    .station_release(rel1), .bus_asserted(asrt1), .bus_source(src1), .bus_value(val1));

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(2)) u_two (
    .clock(clock), .reset(reset), .station_ready(rdy2), .station_result(res2),
    .station_release(rel2), .bus_asserted(asrt2), .bus_source(src2), .bus_value(val2));

  typedef struct {
    int          stamp;
    int          inst;
    int          bus;
    logic [1:0]  src;
    logic [31:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         neg_n  = 0;
  bit         verbose = 1'b1;
  logic [3:0] last_rel1 = '0, last_rel2 = '0;
  int         wait_cnt [2][4];

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic expect_bus(input int inst, input int bus, input int src);
    exp_t e;
    logic [127:0] r;
    r       = (inst == 1) ? res1 : res2;
    e.stamp = neg_n + 1;
    e.inst  = inst;
    e.bus   = bus;
    e.src   = src[1:0];
    e.val   = r[src*32 +: 32];
    exp_q.push_back(e);
  endtask

  task automatic observe(input int inst, input int bus, input logic a,
                         input logic [1:0] s, input logic [31:0] v);
    exp_t e;
    if (a !== 1'b1) return;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL bus_unexpected inst=%0d bus=%0d got src=%0d val=%h required idle", inst, bus, s, v);
      return;
    end
    e = exp_q.pop_front();
    if (e.stamp != neg_n || e.inst != inst || e.bus != bus || e.src !== s || e.val !== v) begin
      errors++;
      $display("FAIL bus_result got inst=%0d bus=%0d cyc=%0d src=%0d val=%h required inst=%0d bus=%0d cyc=%0d src=%0d val=%h",
               inst, bus, neg_n, s, v, e.inst, e.bus, e.stamp, e.src, e.val);
    end else if (verbose) begin
      $display("bus  inst=%0d bus=%0d cyc=%0d src=%0d val=%h", inst, bus, neg_n, s, v);
    end
  endtask

  // Monitor: registered bus outputs are sampled on the falling edge.
  always @(negedge clock) begin
    neg_n++;
    observe(1, 0, asrt1[0], src1, val1);
    observe(2, 0, asrt2[0], src2[1:0], val2[31:0]);
    observe(2, 1, asrt2[1], src2[3:2], val2[63:32]);
    while (exp_q.size() > 0 && exp_q[0].stamp <= neg_n) begin
      checks++;
      errors++;
      $display("FAIL bus_missing got idle required inst=%0d bus=%0d cyc=%0d src=%0d",
               exp_q[0].inst, exp_q[0].bus, exp_q[0].stamp, exp_q[0].src);
      void'(exp_q.pop_front());
    end
  end

  // One clock: drive, check releases, queue the bus results expected after the edge.
  task automatic step(input logic rst, input logic [3:0] r1, input logic [3:0] r2,
                      input logic [3:0] e_rel1, input logic [3:0] e_rel2,
                      input int e1b0, input int e2b0, input int e2b1);
    reset = rst;
    rdy1  = r1;
    rdy2  = r2;
    #1;
    check_val("release_one", rel1, e_rel1);
    check_val("release_two", rel2, e_rel2);
    last_rel1 = rel1;
    last_rel2 = rel2;
    if (verbose)
      $display("step rst=%b ready1=%b ready2=%b release1=%b release2=%b", rst, r1, r2, rel1, rel2);
    @(posedge clock);
    if (e1b0 >= 0) expect_bus(1, 0, e1b0);
    if (e2b0 >= 0) expect_bus(2, 0, e2b0);
    if (e2b1 >= 0) expect_bus(2, 1, e2b1);
    @(negedge clock);
    #1;
  endtask

  task automatic check_cleared();
    check_val("cleared_one", {asrt1, src1, val1}, '0);
    check_val("cleared_two", {asrt2, src2, val2}, '0);
  endtask

  task automatic model(input int nb, input logic [3:0] r, inout int ptr,
                       output logic [3:0] rel, output int b0, output int b1);
    int got;
    got = 0;
    rel = '0;
    b0  = -1;
    b1  = -1;
    for (int off = 0; off < 4; off++) begin
      int idx;
      idx = (ptr + off) % 4;
      if (r[idx] && got < nb) begin
        rel[idx] = 1'b1;
        if (got == 0) b0 = idx;
        else b1 = idx;
        got++;
      end
    end
    if (got > 0) ptr = (((got == 1) ? b0 : b1) + 1) % 4;
  endtask

  task automatic fairness(input int inst, input logic [3:0] r, input logic [3:0] rel, input int limit);
    for (int s = 0; s < 4; s++) begin
      if (r[s] && !rel[s]) begin
        wait_cnt[inst][s]++;
        checks++;
        if (wait_cnt[inst][s] >= limit) begin
          errors++;
          $display("FAIL fairness inst=%0d station=%0d got wait=%0d required below %0d",
                   inst + 1, s, wait_cnt[inst][s], limit);
        end
      end else begin
        wait_cnt[inst][s] = 0;
      end
    end
  endtask

  initial begin
    int         m_ptr1, m_ptr2, a0, c0, c1;
    logic [3:0] r1, r2, e1, e2;
    reset = 1'b1;
    rdy1  = '0;
    rdy2  = '0;
    res1  = {32'hC0DE0003, 32'hDEADBEEF, 32'hC0DE0001, 32'hC0DE0000};
    res2  = {32'hB0B00003, 32'hB0B00002, 32'hB0B00001, 32'hB0B00000};
    @(negedge clock);
    #1;
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1, -1);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1, -1);
    check_cleared();

    // Idle after reset.
    for (int i = 0; i < 5; i++)
      step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1, -1);
    check_cleared();

    // Single producer: station 2 on the single-bus arbiter, then idle with held source/value.
    step(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2, -1, -1);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1, -1);
    check_val("hold_one", {asrt1, src1, val1}, {1'b0, 2'd2, 32'hDEADBEEF});

    // Round robin 0,1,2,3,0 on one bus; dual-bus pointer 3 with stations 0,1,3 on the other.
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1, -1);
    step(0, 4'b1111, 4'b0100, 4'b0001, 4'b0100, 0, 2, -1);
    step(0, 4'b1110, 4'b1011, 4'b0010, 4'b1001, 1, 3, 0);
    step(0, 4'b1101, 4'b0010, 4'b0100, 4'b0010, 2, 1, -1);
    step(0, 4'b1011, 4'b1111, 4'b1000, 4'b1100, 3, 2, 3);
    step(0, 4'b0111, 4'b0011, 4'b0001, 4'b0011, 0, 0, 1);

    // Reset at a grant edge: nothing released, buses clear, pointers return to 0.
    step(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, -1, -1, -1);
    check_cleared();
    step(0, 4'b1111, 4'b1111, 4'b0001, 4'b0011, 0, 0, 1);

    // Random stress against the model; released stations stay low for one cycle.
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1, -1);
    m_ptr1  = 0;
    m_ptr2  = 0;
    verbose = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 4; s++)
        wait_cnt[i][s] = 0;
    for (int c = 0; c < 10000; c++) begin
      r1   = 4'($urandom) & ~last_rel1;
      r2   = 4'($urandom) & ~last_rel2;
      res1 = {$urandom, $urandom, $urandom, $urandom};
      res2 = {$urandom, $urandom, $urandom, $urandom};
      model(1, r1, m_ptr1, e1, a0, c1);
      model(2, r2, m_ptr2, e2, c0, c1);
      step(0, r1, r2, e1, e2, a0, c0, c1);
      fairness(0, r1, last_rel1, 4);
      fairness(1, r2, last_rel2, 2);
    end
    verbose = 1'b1;
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, -1, -1);
    check_val("queue_drained", 128'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
